// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles framed little-endian words into instruction RAM writes
// and holds the CPU in reset until a checksummed frame has loaded. Optional inter-byte timeout via IMEM_LOADER_TIMEOUT_EN.
module imem_loader #(
    parameter int         ADDR_WIDTH     = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR} state_t;

    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

    // The length field is 16 bits, so deeper memories could never be filled by one frame.
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("imem_loader: unsupported parameter values");
    end

    state_t      state;
    state_t      state_next;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] asm_reg;
    logic [7:0]  checksum;

    logic [15:0] len_full;
    logic        last_word;
    logic        is_sync;

    assign len_full  = {rx_data, len_lo};
    assign last_word = (word_idx == len - 16'd1);
    assign is_sync   = rx_valid && (rx_data == SYNC_BYTE);

    assign cpu_reset = (state != DONE);
    assign done      = (state == DONE);
    assign error     = (state == ERR);

`ifdef IMEM_LOADER_TIMEOUT_EN
    logic [31:0] timer;
    logic        frame_active;
    logic        timeout_hit;

    assign frame_active = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CHK);
    assign timeout_hit  = frame_active && !rx_valid && (timer == 32'(TIMEOUT_CYCLES - 1));

    // Counts idle cycles inside a frame; any received byte restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= 32'd0;
        end else if (!frame_active || rx_valid) begin
            timer <= 32'd0;
        end else begin
            timer <= timer + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (is_sync) state_next = LEN_LO;
            LEN_LO: if (rx_valid) state_next = LEN_HI;
            LEN_HI: begin
                if (rx_valid) begin
                    if ({1'b0, len_full} > MAX_WORDS) begin
                        state_next = ERR;
                    end else if (len_full == 16'd0) begin
                        state_next = CHK;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA:   if (rx_valid && byte_idx == 2'd3 && last_word) state_next = CHK;
            CHK:    if (rx_valid) state_next = (rx_data == checksum) ? DONE : ERR;
            DONE,
            ERR:    if (is_sync) state_next = LEN_LO;
            default: state_next = IDLE;
        endcase
`ifdef IMEM_LOADER_TIMEOUT_EN
        if (timeout_hit) state_next = ERR;
`endif
    end

    // Word assembly keeps b2..b0 in asm_reg so a fresh byte can arrive during a write pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we       <= 1'b0;
            waddr    <= 32'd0;
            wdata    <= 32'd0;
            len_lo   <= 8'd0;
            len      <= 16'd0;
            word_idx <= 16'd0;
            byte_idx <= 2'd0;
            asm_reg  <= 24'd0;
            checksum <= 8'd0;
        end else begin
            we <= 1'b0;
            if (state == LEN_LO && rx_valid) begin
                len_lo <= rx_data;
            end
            if (state == LEN_HI && rx_valid) begin
                len      <= len_full;
                word_idx <= 16'd0;
                byte_idx <= 2'd0;
                checksum <= 8'd0;
            end
            if (state == DATA && rx_valid) begin
                checksum <= checksum + rx_data;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    we       <= 1'b1;
                    waddr    <= {{(30 - ADDR_WIDTH){1'b0}}, word_idx[ADDR_WIDTH-1:0], 2'b00};
                    wdata    <= {rx_data, asm_reg};
                    word_idx <= word_idx + 16'd1;
                end else begin
                    asm_reg <= {rx_data, asm_reg[23:8]};
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: frames are driven byte by byte and RAM writes are logged
// from the write port; the timeout expectation follows IMEM_LOADER_TIMEOUT_EN.
module tb_imem_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    byte_q_t     frame;

    imem_loader #(
        .ADDR_WIDTH    (8),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .cpu_reset(cpu_reset),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log, sampled half a cycle after the edge that raises we.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_addr.push_back(waddr);
            wr_data.push_back(wdata);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input byte_q_t bytes);
        foreach (bytes[i]) applyStimulus(bytes[i]);
    endtask

    task automatic start_test();
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic check_status(input string tag, input logic exp_done, input logic exp_err, input logic exp_cpu);
        checkOutput({tag, "_done"}, 32'(done), 32'(exp_done));
        checkOutput({tag, "_error"}, 32'(error), 32'(exp_err));
        checkOutput({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(exp_cpu));
    endtask

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_we", 32'(we), 32'd0);
        checkOutput("rst_waddr", waddr, 32'd0);
        checkOutput("rst_wdata", wdata, 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b1);
        reset = 1'b0;

        // Good two-word load
        start_test();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'hD7};
        send_frame(frame);
        check_status("good", 1'b1, 1'b0, 1'b0);
        checkOutput("good_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            checkOutput("good_a0", wr_addr[0], 32'h0);
            checkOutput("good_d0", wr_data[0], 32'h00A00093);
            checkOutput("good_a1", wr_addr[1], 32'h4);
            checkOutput("good_d1", wr_data[1], 32'h00108113);
        end
        checkOutput("good_hold_waddr", waddr, 32'h4);

        // Bad checksum, then recovery
        start_test();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'hD6};
        send_frame(frame);
        check_status("badchk", 1'b0, 1'b1, 1'b1);
        checkOutput("badchk_nwr", 32'(wr_addr.size()), 32'd2);
        applyStimulus(8'hA5);
        check_status("restart", 1'b0, 1'b0, 1'b1);
        frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'hD7};
        send_frame(frame);
        check_status("recover", 1'b1, 1'b0, 1'b0);

        // Oversize length (257 words)
        start_test();
        frame = '{8'hA5, 8'h01, 8'h01};
        send_frame(frame);
        check_status("oversize", 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("oversize_nwr", 32'(wr_addr.size()), 32'd0);

        // Noise is ignored, zero-length frame loads
        start_test();
        frame = '{8'h00, 8'hFF, 8'h5A};
        send_frame(frame);
        check_status("noise", 1'b0, 1'b1, 1'b1);
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(frame);
        check_status("zerolen", 1'b1, 1'b0, 1'b0);
        checkOutput("zerolen_nwr", 32'(wr_addr.size()), 32'd0);

        // Reset mid-frame
        start_test();
        frame = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_frame(frame);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_we", 32'(we), 32'd0);
        checkOutput("midrst_waddr", waddr, 32'd0);
        checkOutput("midrst_wdata", wdata, 32'd0);
        check_status("midrst", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        frame = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        send_frame(frame);
        check_status("afterrst", 1'b1, 1'b0, 1'b0);
        checkOutput("afterrst_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            checkOutput("afterrst_a0", wr_addr[0], 32'h0);
            checkOutput("afterrst_d0", wr_data[0], 32'h12345678);
        end

        // Full 256-word load: word i = {i,i,i,i}, byte sum wraps to 0x00
        start_test();
        frame = '{8'hA5, 8'h00, 8'h01};
        send_frame(frame);
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 4; k++) applyStimulus(8'(i));
        end
        applyStimulus(8'h00);
        check_status("full", 1'b1, 1'b0, 1'b0);
        checkOutput("full_nwr", 32'(wr_addr.size()), 32'd256);
        if (wr_addr.size() == 256) begin
            checkOutput("full_a1", wr_addr[1], 32'h4);
            checkOutput("full_d1", wr_data[1], 32'h01010101);
            checkOutput("full_alast", wr_addr[255], 32'h3FC);
            checkOutput("full_dlast", wr_data[255], 32'hFFFFFFFF);
        end

        // Partial frame followed by 100 idle cycles
        start_test();
        frame = '{8'hA5, 8'h02};
        send_frame(frame);
        repeat (100) @(negedge clk);
`ifdef IMEM_LOADER_TIMEOUT_EN
        check_status("timeout", 1'b0, 1'b1, 1'b1);
`else
        check_status("notimeout", 1'b0, 1'b0, 1'b1);
`endif
        checkOutput("timeout_nwr", 32'(wr_addr.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
